gate_sweep_checker: RTL and testbench

Parametrised, self-sequencing exhaustive checker for N-input logic gates. It drives every input combination of an N-input gate under test and computes the expected output for a selected gate function (AND/OR/NAND/NOR/XOR/XNOR). It samples the gate's response after a configurable hold time and reports the mismatch count and the first failing vector. It sits beside a combinational gate module on the board or in simulation and replaces free-running toggle stimulus with a repeatable, clocked sweep that has a start/done handshake.

---
 rtl/gate_sweep_checker_if.sv | 27 ++
 rtl/gate_sweep_checker.sv | 109 ++++++++++
 tb/tb_gate_sweep_checker.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/gate_sweep_checker_if.sv
// Stimulus/response bundle between the sweep checker and whoever drives it.
// The checker takes the slave side.
interface gate_sweep_checker_if #(
    parameter int N = 4
);
    logic         start;
    logic [2:0]   mode;
    logic         dut_y;
    logic [N-1:0] vec;
    logic         vec_valid;
    logic         exp_y;
    logic         busy;
    logic         done;
    logic [N:0]   err_cnt;
    logic [N-1:0] first_err_vec;
    logic         first_err_valid;

    modport master (
        output start, mode, dut_y,
        input  vec, vec_valid, exp_y, busy, done, err_cnt, first_err_vec, first_err_valid
    );

    modport slave (
        input  start, mode, dut_y,
        output vec, vec_valid, exp_y, busy, done, err_cnt, first_err_vec, first_err_valid
    );
endinterface

// File: rtl/gate_sweep_checker.sv
// Exhaustive clocked sweep of an N-input gate: drives every vector, holds it
// HOLD cycles, compares the gate output against the selected function.
//
// state | meaning
// IDLE  | waiting for start with a legal mode
// RUN   | driving vectors, sampling dut_y at the end of each hold window
// DONE  | one-cycle done pulse, results retained
module gate_sweep_checker #(
    parameter int N    = 4,
    parameter int HOLD = 4
) (
    input logic              clk,
    input logic              rst_n,
    gate_sweep_checker_if.slave bus
);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t       state, state_nxt;
    logic [2:0]   mode_q;
    logic [7:0]   hold_cnt;
    logic [N-1:0] vec_q;
    logic [N-1:0] vec_inc;
    logic         exp_q;
    logic [N:0]   err_q;
    logic [N-1:0] ferr_q;
    logic         fval_q;
    logic         accept;
    logic         sample;
    logic         last_vec;

    function automatic logic gate_fn(input logic [2:0] m, input logic [N-1:0] v);
        case (m)
            3'd0:    return &v;
            3'd1:    return |v;
            3'd2:    return ~&v;
            3'd3:    return ~|v;
            3'd4:    return ^v;
            3'd5:    return ~^v;
            default: return 1'b0;
        endcase
    endfunction

    assign accept   = (state == IDLE) && bus.start && (bus.mode <= 3'd5);
    assign sample   = (state == RUN) && (hold_cnt == HOLD_LAST);
    assign last_vec = &vec_q;
    // Incrementing all-ones wraps to zero, which is exactly the post-sweep vec.
    assign vec_inc  = vec_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (sample && last_vec) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= 3'd0;
            hold_cnt <= 8'd0;
            vec_q    <= '0;
            exp_q    <= 1'b0;
            err_q    <= '0;
            ferr_q   <= '0;
            fval_q   <= 1'b0;
        end else if (accept) begin
            mode_q   <= bus.mode;
            hold_cnt <= 8'd0;
            vec_q    <= '0;
            exp_q    <= gate_fn(bus.mode, '0);
            err_q    <= '0;
            ferr_q   <= '0;
            fval_q   <= 1'b0;
        end else if (state == RUN) begin
            if (sample) begin
                hold_cnt <= 8'd0;
                vec_q    <= vec_inc;
                exp_q    <= gate_fn(mode_q, vec_inc);
                if (bus.dut_y != exp_q) begin
                    err_q <= err_q + 1'b1;
                    if (!fval_q) begin
                        ferr_q <= vec_q;
                        fval_q <= 1'b1;
                    end
                end
            end else begin
                hold_cnt <= hold_cnt + 8'd1;
            end
        end
    end

    assign bus.vec             = vec_q;
    assign bus.vec_valid       = (state == RUN);
    assign bus.busy            = (state == RUN);
    assign bus.done            = (state == DONE);
    assign bus.exp_y           = exp_q;
    assign bus.err_cnt         = err_q;
    assign bus.first_err_vec   = ferr_q;
    assign bus.first_err_valid = fval_q;
endmodule

// File: tb/tb_gate_sweep_checker.sv
// Scoreboard bench for gate_sweep_checker: three instances (N/HOLD = 4/4, 4/2, 2/1),
// expected sweep results queued at start, checked by per-instance monitors on done.
module tb_gate_sweep_checker;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gate_sweep_checker_if #(.N(4)) ifa ();
    gate_sweep_checker_if #(.N(4)) ifb ();
    gate_sweep_checker_if #(.N(2)) ifc ();

    gate_sweep_checker #(.N(4), .HOLD(4)) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    gate_sweep_checker #(.N(4), .HOLD(2)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
    gate_sweep_checker #(.N(2), .HOLD(1)) u_c (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

    typedef struct {int len; int err; int fvec; int fval;} exp_t;

    exp_t sbq [3][$];
    int   bcnt [3]     = '{0, 0, 0};
    bit   pdone [3]    = '{0, 0, 0};
    int   cur_mode [3] = '{3, 4, 0};
    int   hold [3]     = '{4, 2, 1};
    int   nbits [3]    = '{4, 4, 2};
    int   dsel_a       = 0;
    int   checks       = 0;
    int   errors       = 0;

    // Reference gate over the low n bits of v.
    function automatic logic gfun(input int m, input logic [7:0] v, input int n);
        logic [7:0] mask;
        logic [7:0] w;
        mask = 8'((1 << n) - 1);
        w    = v & mask;
        case (m)
            0:       return (w == mask);
            1:       return (w != 8'd0);
            2:       return (w != mask);
            3:       return (w == 8'd0);
            4:       return ^w;
            5:       return ~^w;
            default: return 1'b0;
        endcase
    endfunction

    // Instance A: 0 ideal gate, 1 stuck at 0, 2 NOR with wrong outputs at vec 3 and 9
    assign ifa.dut_y = (dsel_a == 0) ? gfun(cur_mode[0], 8'(ifa.vec), 4) :
                       (dsel_a == 1) ? 1'b0 :
                       (gfun(3, 8'(ifa.vec), 4) ^ ((ifa.vec == 4'd3) || (ifa.vec == 4'd9)));
    assign ifb.dut_y = gfun(3, 8'(ifb.vec), 4);
    assign ifc.dut_y = gfun(0, 8'(ifc.vec), 2);

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic mon_step(input int k, input logic done, input logic vv, input logic busy,
                            input logic [7:0] vec, input logic ey, input logic [8:0] err,
                            input logic [7:0] fvec, input logic fval);
        exp_t e;
        if (!rst_n) begin
            bcnt[k]  = 0;
            pdone[k] = 1'b0;
            sbq[k].delete();
            return;
        end
        if (pdone[k]) check($sformatf("done_pulse_len[%0d]", k), int'(done), 0);
        pdone[k] = done;
        if (vv) begin
            check($sformatf("vec_order[%0d]", k), int'(vec), bcnt[k] / hold[k]);
            check($sformatf("exp_y[%0d] vec=%0d", k, vec), int'(ey),
                  int'(gfun(cur_mode[k], vec, nbits[k])));
        end
        if (busy) bcnt[k]++;
        if (done) begin
            if (sbq[k].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done[%0d] actual 1 required 0", k);
            end else begin
                e = sbq[k].pop_front();
                check($sformatf("sweep_len[%0d]", k), bcnt[k], e.len);
                check($sformatf("err_cnt[%0d]", k), int'(err), e.err);
                check($sformatf("first_err_vec[%0d]", k), int'(fvec), e.fvec);
                check($sformatf("first_err_valid[%0d]", k), int'(fval), e.fval);
            end
            bcnt[k] = 0;
        end
    endtask

    always @(negedge clk) mon_step(0, ifa.done, ifa.vec_valid, ifa.busy, 8'(ifa.vec), ifa.exp_y,
                                   9'(ifa.err_cnt), 8'(ifa.first_err_vec), ifa.first_err_valid);
    always @(negedge clk) mon_step(1, ifb.done, ifb.vec_valid, ifb.busy, 8'(ifb.vec), ifb.exp_y,
                                   9'(ifb.err_cnt), 8'(ifb.first_err_vec), ifb.first_err_valid);
    always @(negedge clk) mon_step(2, ifc.done, ifc.vec_valid, ifc.busy, 8'(ifc.vec), ifc.exp_y,
                                   9'(ifc.err_cnt), 8'(ifc.first_err_vec), ifc.first_err_valid);

    task automatic go(input int k, input int m);
        cur_mode[k] = m;
        @(negedge clk);
        case (k)
            0:       begin ifa.start = 1'b1; ifa.mode = 3'(m); end
            1:       begin ifb.start = 1'b1; ifb.mode = 3'(m); end
            default: begin ifc.start = 1'b1; ifc.mode = 3'(m); end
        endcase
        @(negedge clk);
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        ifc.start = 1'b0;
    endtask

    task automatic wait_done(input int k);
        bit seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ((k == 0 && ifa.done) || (k == 1 && ifb.done) || (k == 2 && ifc.done)) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout[%0d] actual 0 required 1", k);
        end
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, "_vec"}, int'(ifa.vec), 0);
        check({tag, "_vec_valid"}, int'(ifa.vec_valid), 0);
        check({tag, "_exp_y"}, int'(ifa.exp_y), 0);
        check({tag, "_busy"}, int'(ifa.busy), 0);
        check({tag, "_done"}, int'(ifa.done), 0);
        check({tag, "_err_cnt"}, int'(ifa.err_cnt), 0);
        check({tag, "_first_err_vec"}, int'(ifa.first_err_vec), 0);
        check({tag, "_first_err_valid"}, int'(ifa.first_err_valid), 0);
    endtask

    initial begin
        bit hit;
        ifa.start = 1'b0; ifa.mode = 3'd0;
        ifb.start = 1'b0; ifb.mode = 3'd0;
        ifc.start = 1'b0; ifc.mode = 3'd0;
        #23;
        check_a_zero("reset");
        check("reset_c_busy", int'(ifc.busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // ideal NOR: clean sweep, 16 vectors x 4 cycles
        dsel_a = 0;
        sbq[0].push_back('{64, 0, 0, 0});
        go(0, 3);
        wait_done(0);

        // stuck-at-0 against NOR: only vec 0 mismatches
        dsel_a = 1;
        sbq[0].push_back('{64, 1, 0, 1});
        go(0, 3);
        wait_done(0);

        // illegal mode in IDLE is ignored, results retained
        @(negedge clk);
        ifa.start = 1'b1; ifa.mode = 3'd6;
        @(negedge clk);
        ifa.start = 1'b0; ifa.mode = 3'd3;
        check("mode6_busy", int'(ifa.busy), 0);
        check("mode6_vec_valid", int'(ifa.vec_valid), 0);
        check("mode6_done", int'(ifa.done), 0);
        check("mode6_err_cnt", int'(ifa.err_cnt), 1);
        check("mode6_first_err_valid", int'(ifa.first_err_valid), 1);
        check("mode6_exp_y", int'(ifa.exp_y), 1);

        // XOR expected vs NOR gate: vec 0 plus the 8 odd-parity non-zero vectors
        sbq[1].push_back('{32, 9, 0, 1});
        go(1, 4);
        wait_done(1);

        // N=2, HOLD=1 AND
        sbq[2].push_back('{4, 0, 0, 0});
        go(2, 0);
        wait_done(2);

        // start with a different mode mid-sweep must not restart or relatch
        dsel_a = 0;
        sbq[0].push_back('{64, 0, 0, 0});
        go(0, 3);
        repeat (10) @(negedge clk);
        ifa.start = 1'b1; ifa.mode = 3'd1;
        @(negedge clk);
        ifa.start = 1'b0; ifa.mode = 3'd3;
        wait_done(0);

        // faulty NOR: two mismatches, first at vec 3
        dsel_a = 2;
        sbq[0].push_back('{64, 2, 3, 1});
        go(0, 3);
        wait_done(0);

        // abort at vector 7 via reset
        dsel_a = 0;
        sbq[0].push_back('{64, 0, 0, 0});
        go(0, 3);
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ifa.vec == 4'd7) begin
                hit = 1'b1;
                break;
            end
        end
        check("reached_vec7", int'(hit), 1);
        #3 rst_n = 1'b0;
        #1 check_a_zero("abort");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("post_abort_busy", int'(ifa.busy), 0);
        check("post_abort_done", int'(ifa.done), 0);

        sbq[0].push_back('{64, 0, 0, 0});
        go(0, 3);
        wait_done(0);
        repeat (3) @(negedge clk);

        for (int k = 0; k < 3; k++) check($sformatf("sb_drained[%0d]", k), sbq[k].size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
